// File: rtl/cam_match_iter.sv
// cam_match_iter: multi-match resolver for the CAM lookup path.
//
// Takes a WIDTH-bit match vector and emits the index of every set bit,
// one index per beat, in priority order (LSB-first unless MSB_FIRST = 1).
// A first-only request returns just the highest-priority match.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  input handshake; ready only while idle
//   in_match        match vector (bit i set = entry i matched)
//   in_first_only   sampled with the vector; emit only the top match
//   out_valid/ready output beat handshake
//   out_addr        index of the current match
//   out_hit         1 = real match, 0 = vector was all-zero
//   out_last        final beat for this vector
//   out_seq         beat number within the vector, from 0
module cam_match_iter #(
  parameter int WIDTH     = 64,
  parameter int MSB_FIRST = 0,
  parameter int ADDR_W    = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_match,
  input  logic              in_first_only,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_hit,
  output logic              out_last,
  output logic [ADDR_W-1:0] out_seq
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic                first_q, first_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                out_hit_q, out_hit_d;
  logic                out_last_q, out_last_d;
  logic [ADDR_W-1:0]   out_seq_q, out_seq_d;
  logic [WIDTH-1:0]    rem_clr;

  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  // One-hot of the highest-priority set bit. The lowest set bit is
  // isolated with v & -v (a single carry chain); MSB-first reuses the same
  // trick on the bit-reversed vector.
  function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = (MSB_FIRST != 0) ? rev(v) : v;
    r = r & (~r + WIDTH'(1));
    return (MSB_FIRST != 0) ? rev(r) : r;
  endfunction

  // One-hot to binary as an OR of the indices of set bits.
  function automatic logic [ADDR_W-1:0] enc(input logic [WIDTH-1:0] oh);
    logic [ADDR_W-1:0] a;
    a = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (oh[i]) a = a | ADDR_W'(i);
    end
    return a;
  endfunction

  // True when v has at most one bit set: that beat is the final one.
  function automatic logic at_most_one(input logic [WIDTH-1:0] v);
    return (v & (v - WIDTH'(1))) == '0;
  endfunction

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_hit   = out_hit_q;
  assign out_last  = out_last_q;
  assign out_seq   = out_seq_q;

  // Clearing the bit being emitted uses a decode of the registered
  // out_addr, keeping one priority chain on the advance path.
  assign rem_clr = rem_q & ~(WIDTH'(1) << out_addr_q);

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_hit_d   = out_hit_q;
    out_last_d  = out_last_q;
    out_seq_d   = out_seq_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d     = SCAN;
          rem_d       = in_match;
          first_d     = in_first_only;
          out_valid_d = 1'b1;
          out_addr_d  = enc(pick(in_match));
          out_hit_d   = |in_match;
          out_last_d  = in_first_only || at_most_one(in_match);
          out_seq_d   = '0;
        end
      end
      SCAN: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end else begin
            rem_d      = rem_clr;
            out_addr_d = enc(pick(rem_clr));
            out_last_d = first_q || at_most_one(rem_clr);
            out_seq_d  = out_seq_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_hit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_seq_q   <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_hit_q   <= out_hit_d;
      out_last_q  <= out_last_d;
      out_seq_q   <= out_seq_d;
    end
  end

endmodule

// File: tb/tb_cam_match_iter.sv
module tb_cam_match_iter;

  localparam int W  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_match;
  logic          in_first_only;
  logic          out_ready;

  logic          l_in_ready, l_out_valid, l_out_hit, l_out_last;
  logic [AW-1:0] l_out_addr, l_out_seq;
  logic          m_in_ready, m_out_valid, m_out_hit, m_out_last;
  logic [AW-1:0] m_out_addr, m_out_seq;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cam_match_iter #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_match(in_match), .in_first_only(in_first_only),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_addr(l_out_addr),
    .out_hit(l_out_hit), .out_last(l_out_last), .out_seq(l_out_seq)
  );

  cam_match_iter #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_match(in_match), .in_first_only(in_first_only),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_addr(m_out_addr),
    .out_hit(m_out_hit), .out_last(m_out_last), .out_seq(m_out_seq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the currently presented beat of one instance.
  task automatic beat(input string tag, input bit msb, input int addr,
                      input int seq, input bit last, input bit hit);
    if (msb) begin
      chk({tag, " m.valid"}, 32'(m_out_valid), 32'd1);
      chk({tag, " m.addr"},  32'(m_out_addr),  32'(addr));
      chk({tag, " m.seq"},   32'(m_out_seq),   32'(seq));
      chk({tag, " m.last"},  32'(m_out_last),  32'(last));
      chk({tag, " m.hit"},   32'(m_out_hit),   32'(hit));
    end else begin
      chk({tag, " l.valid"}, 32'(l_out_valid), 32'd1);
      chk({tag, " l.addr"},  32'(l_out_addr),  32'(addr));
      chk({tag, " l.seq"},   32'(l_out_seq),   32'(seq));
      chk({tag, " l.last"},  32'(l_out_last),  32'(last));
      chk({tag, " l.hit"},   32'(l_out_hit),   32'(hit));
    end
    $display("beat %s msb=%0d addr=%0d seq=%0d last=%0d hit=%0d", tag, msb,
             msb ? m_out_addr : l_out_addr, msb ? m_out_seq : l_out_seq,
             msb ? m_out_last : l_out_last, msb ? m_out_hit : l_out_hit);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, " l.valid0"}, 32'(l_out_valid), 32'd0);
    chk({tag, " m.valid0"}, 32'(m_out_valid), 32'd0);
    chk({tag, " l.ready1"}, 32'(l_in_ready),  32'd1);
    chk({tag, " m.ready1"}, 32'(m_in_ready),  32'd1);
  endtask

  // Offer a vector for exactly one (accepting) edge.
  task automatic offer(input logic [W-1:0] v, input bit fo);
    in_valid = 1'b1; in_match = v; in_first_only = fo;
    step();
    in_valid = 1'b0; in_first_only = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_match = '0; in_first_only = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst in_ready", 32'(l_in_ready), 32'd0);
    step(); step();
    chk("rst out_valid", 32'(l_out_valid), 32'd0);
    chk("rst out_addr",  32'(l_out_addr),  32'd0);
    chk("rst out_seq",   32'(l_out_seq),   32'd0);
    chk("rst out_last",  32'(l_out_last),  32'd0);
    chk("rst out_hit",   32'(l_out_hit),   32'd0);
    chk("rst m_in_ready", 32'(m_in_ready), 32'd0);
    rst = 1'b0;
    #1;
    idle_chk("post-rst");

    // 1010_0100: LSB 2,5,7 ; MSB 7,5,2
    offer(8'b1010_0100, 1'b0);
    beat("a4 b0", 0, 2, 0, 0, 1); beat("a4 b0", 1, 7, 0, 0, 1);
    chk("a4 in_ready busy", 32'(l_in_ready), 32'd0);
    step();
    beat("a4 b1", 0, 5, 1, 0, 1); beat("a4 b1", 1, 5, 1, 0, 1);
    step();
    beat("a4 b2", 0, 7, 2, 1, 1); beat("a4 b2", 1, 2, 2, 1, 1);
    step();
    idle_chk("a4 done");

    // all-zero vector: one miss beat
    offer(8'h00, 1'b0);
    beat("zero", 0, 0, 0, 1, 0); beat("zero", 1, 0, 0, 1, 0);
    step();
    idle_chk("zero done");

    // 8'hFF with backpressure; a vector offered mid-scan must be ignored
    offer(8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      beat($sformatf("ff b%0d", i), 0, i, i, i == 7, 1);
      beat($sformatf("ff b%0d", i), 1, 7 - i, i, i == 7, 1);
      out_ready = 1'b0;
      in_valid = 1'b1; in_match = 8'h01;
      step();
      beat($sformatf("ff hold%0d", i), 0, i, i, i == 7, 1);
      beat($sformatf("ff hold%0d", i), 1, 7 - i, i, i == 7, 1);
      chk($sformatf("ff in_ready%0d", i), 32'(l_in_ready), 32'd0);
      step();
      chk($sformatf("ff hold2 addr%0d", i), 32'(l_out_addr), 32'(i));
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
    end
    idle_chk("ff done");

    // first-only: one beat with the top match
    offer(8'b1111_0000, 1'b1);
    beat("fo", 0, 4, 0, 1, 1); beat("fo", 1, 7, 0, 1, 1);
    step();
    idle_chk("fo done");
    offer(8'b0000_1100, 1'b0);
    beat("0c b0", 0, 2, 0, 0, 1); beat("0c b0", 1, 3, 0, 0, 1);
    step();
    beat("0c b1", 0, 3, 1, 1, 1); beat("0c b1", 1, 2, 1, 1, 1);
    step();
    idle_chk("0c done");

    // reset mid-scan
    offer(8'b0110_0110, 1'b0);
    beat("66 b0", 0, 1, 0, 0, 1); beat("66 b0", 1, 6, 0, 0, 1);
    step();
    beat("66 b1", 0, 2, 1, 0, 1); beat("66 b1", 1, 5, 1, 0, 1);
    rst = 1'b1;
    step();
    chk("midrst l.valid", 32'(l_out_valid), 32'd0);
    chk("midrst m.valid", 32'(m_out_valid), 32'd0);
    chk("midrst in_ready", 32'(l_in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("postrst in_ready", 32'(l_in_ready), 32'd1);
    step();
    chk("postrst no beat", 32'(l_out_valid), 32'd0);
    offer(8'b0000_1000, 1'b0);
    beat("08", 0, 3, 0, 1, 1); beat("08", 1, 3, 0, 1, 1);
    step();
    idle_chk("08 done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_match_iter.md
Name: cam_match_iter

Overview:
- Parametrised multi-match resolver for the CAM lookup path.
- Accepts a WIDTH-bit match vector and emits the index of every set bit, one index per beat, in priority order (LSB-first by default), with valid/ready handshakes on both sides.
- Replaces the single-result fixed 8:3 encoder wherever all matching entries must be visited.
- Optional first-only mode returns just the highest-priority match.

Parameters:
- WIDTH, 64: match vector width; legal range >= 2.
- MSB_FIRST, 0: 0 = lowest index has priority; 1 = highest index has priority.
- ADDR_W, $clog2(WIDTH): index width. Derived; do not override.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  match vector offered
- in_ready  out  1  block can accept a vector
- in_match  in  WIDTH  match vector; bit i set = entry i matched
- in_first_only  in  1  sampled with the vector; emit only the highest-priority match
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts the beat
- out_addr  out  ADDR_W  index of the current match
- out_hit  out  1  1 = out_addr is a real match; 0 = vector was all-zero
- out_last  out  1  final beat for this vector
- out_seq  out  ADDR_W  beat number within the vector, starting at 0

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); it is sampled only on the rising edge of clk.
- Reset values: state IDLE, rem = 0, out_valid 0, out_addr 0, out_hit 0, out_last 0, out_seq 0. in_ready = 0 while rst = 1.
- States:
  - IDLE: in_ready = 1. On in_valid && in_ready, load rem <= in_match, latch in_first_only, go to SCAN.
  - SCAN: in_ready = 0. in_valid is ignored and the vector is not captured.
- Output registers: out_valid, out_addr, out_hit, out_last and out_seq are all registers. out_valid rises in the cycle after input acceptance (latency 1).
- out_addr = priority index of rem:
  - MSB_FIRST = 0: lowest set bit.
  - MSB_FIRST = 1: highest set bit.
- out_last = 1 when any of these holds: rem has exactly one bit set, rem = 0, or first-only is latched.
- Beat handshake: a beat transfers on out_valid && out_ready. On transfer:
  - If out_last: clear out_valid, return to IDLE. in_ready is 1 in the next cycle, so there is one idle cycle minimum between vectors.
  - Else: rem <= rem with the out_addr bit cleared; out_seq <= out_seq + 1; out_addr and out_last are recomputed from the new rem and registered in the same edge. This gives one beat per cycle when out_ready is held high.
- Backpressure: while out_valid && !out_ready, out_addr, out_hit, out_last, out_seq and rem all hold. There is no combinational path from out_ready to any output.
- All-zero vector: exactly one beat, with out_hit = 0, out_last = 1, out_addr = 0, out_seq = 0.
- First-only: exactly one beat with the highest-priority index, out_last = 1. Remaining bits are discarded.
- Bit count: a vector with k set bits (k >= 1, first-only clear) produces exactly k beats, with out_seq 0 .. k-1. out_seq never wraps, because k <= WIDTH.
- Reset mid-SCAN: on the edge where rst = 1, the in-flight vector is discarded and out_valid is 0 after that edge. The block returns to IDLE, with in_ready = 1 in the first cycle with rst = 0.
- Priority logic is a parametrised loop or tree over WIDTH, not a fixed case table. The combinational depth must meet timing at WIDTH = 64.

Test Plan:
- WIDTH=8, MSB_FIRST=0, in_match=8'b1010_0100, out_ready=1 -> beats out_addr 2,5,7 on consecutive cycles; out_seq 0,1,2; out_last only on the beat with 7; out_hit=1 on all beats; in_ready=1 in the cycle after the last beat.
- in_match=8'h00 -> one beat with out_hit=0, out_last=1, out_addr=0, out_seq=0; then back to IDLE.
- MSB_FIRST=1, in_match=8'b1010_0100 -> beats out_addr 7,5,2; out_last on the beat with 2.
- in_match=8'hFF, out_ready toggled 1,0,0,1,... -> out_addr sequence 0..7 with no skipped or duplicated index; out_addr/out_seq stable during out_ready=0; out_valid drives in_valid ignored while in SCAN (second vector offered mid-scan is not captured).
- in_first_only=1, in_match=8'b1111_0000 -> single beat with out_addr=4, out_last=1, out_seq=0; next vector accepted normally.
- in_match=8'b0110_0110, rst=1 pulsed after the second beat -> out_valid=0 after the reset edge, no further beats; a new vector 8'b0000_1000 is accepted -> single beat with out_addr=3, out_seq=0.
